// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/trap outputs of the program-counter sequencer
interface pc_sequencer_if #(parameter int NUM_IRQ = 4);
  logic               stall;
  logic [2:0]         pcsrc;
  logic               branch_taken;
  logic [15:0]        imm16;
  logic [25:0]        jidx;
  logic [31:0]        jr_target;
  logic               illegal_op;
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [31:0]        epc;
  logic               kernel;
  logic               trap;
  logic               trap_irq;
  logic [2:0]         trap_id;
  logic [31:0]        link_value;
  logic [NUM_IRQ-1:0] pending;
  modport master (
    output stall, pcsrc, branch_taken, imm16, jidx, jr_target, illegal_op, irq, irq_mask,
    input  pc, pc_plus4, epc, kernel, trap, trap_irq, trap_id, link_value, pending
  );
  modport slave (
    input  stall, pcsrc, branch_taken, imm16, jidx, jr_target, illegal_op, irq, irq_mask,
    output pc, pc_plus4, epc, kernel, trap, trap_irq, trap_id, link_value, pending
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/EPC register, next-PC select and irq/exception trap arbitration (PC_SEQ_VECTORED_IRQ_EN selects per-line vectors)
module pc_sequencer #(
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);
  logic [31:0]        pc_q, epc_q, pc_d, epc_d, pc_plus4, vector, br_target;
  logic [NUM_IRQ-1:0] pend_q, pend_d, irq_q, enabled, clr;
  logic [2:0]         id;
  logic               kernel, irq_take, exc_take;
  assign kernel    = pc_q[31];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign enabled   = pend_q & bus.irq_mask;
  assign irq_take  = ~reset & (|enabled) & ~kernel & ~bus.stall;
  assign exc_take  = ~reset & bus.illegal_op & ~kernel & ~bus.stall & ~irq_take;
`ifdef PC_SEQ_VECTORED_IRQ_EN
  assign vector = IRQ_VECTOR + {25'd0, id, 4'd0};
`else
  assign vector = IRQ_VECTOR;
`endif
  // lowest enabled index wins; only the serviced line is cleared
  always_comb begin
    id  = '0;
    clr = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (enabled[i]) id = 3'(i);
    for (int i = 0; i < NUM_IRQ; i++)
      clr[i] = irq_take && (id == 3'(i));
  end
  assign pend_d = (pend_q | (bus.irq & ~irq_q)) & ~clr;
  assign epc_d  = irq_take ? pc_q : exc_take ? pc_plus4 : epc_q;
  assign pc_d   = bus.stall            ? pc_q :
                  irq_take             ? vector :
                  exc_take             ? EXC_VECTOR :
                  bus.pcsrc == 3'b001  ? (bus.branch_taken ? br_target : pc_plus4) :
                  bus.pcsrc == 3'b010  ? {pc_plus4[31:28], bus.jidx, 2'b00} :
                  bus.pcsrc == 3'b011  ? bus.jr_target :
                  bus.pcsrc == 3'b100  ? epc_q : pc_plus4;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VECTOR;
      epc_q  <= '0;
      pend_q <= '0;
      irq_q  <= '0;
    end else begin
      pc_q   <= pc_d;
      epc_q  <= epc_d;
      pend_q <= pend_d;
      irq_q  <= bus.irq;
    end
  end
  assign bus.pc         = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.epc        = epc_q;
  assign bus.kernel     = kernel;
  assign bus.trap       = irq_take | exc_take;
  assign bus.trap_irq   = irq_take;
  assign bus.trap_id    = irq_take ? id : 3'd0;
  assign bus.link_value = irq_take ? pc_q : pc_plus4;
  assign bus.pending    = pend_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a cycle-level reference model of the PC/trap rules
module tb_pc_sequencer;
  localparam int N = 4;
`ifdef PC_SEQ_VECTORED_IRQ_EN
  localparam logic [31:0] VEC1 = 32'h8000_0014, VEC2 = 32'h8000_0024;
  localparam bit VECTORED = 1'b1;
`else
  localparam logic [31:0] VEC1 = 32'h8000_0004, VEC2 = 32'h8000_0004;
  localparam bit VECTORED = 1'b0;
`endif
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0;
  pc_sequencer_if #(.NUM_IRQ(N)) bus ();
  pc_sequencer #(.NUM_IRQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [31:0] m_pc, m_epc, n_pc, n_epc;
  bit m_pend[N], m_prev[N], n_pend[N];

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) model_reset();
      begin
        logic [31:0] pp4, vec, link;
        bit k, itake, etake;
        int id;
        logic [N-1:0] pend_v;
        pp4 = m_pc + 32'd4;
        k = m_pc[31];
        id = -1;
        for (int i = 0; i < N; i++)
          if (id < 0 && m_pend[i] && bus.irq_mask[i]) id = i;
        itake = !reset && id >= 0 && !k && !bus.stall;
        etake = !reset && bus.illegal_op && !k && !bus.stall && !itake;
        vec = VECTORED ? 32'h8000_0004 + 32'(id) * 16 : 32'h8000_0004;
        link = itake ? m_pc : pp4;
        for (int i = 0; i < N; i++) pend_v[i] = m_pend[i];
        chk("pc", bus.pc, m_pc);
        chk("pc_plus4", bus.pc_plus4, pp4);
        chk("epc", bus.epc, m_epc);
        chk("kernel", 32'(bus.kernel), 32'(k));
        chk("trap", 32'(bus.trap), 32'(itake || etake));
        chk("trap_irq", 32'(bus.trap_irq), 32'(itake));
        chk("trap_id", 32'(bus.trap_id), itake ? 32'(id) : 32'd0);
        chk("link_value", bus.link_value, link);
        chk("pending", 32'(bus.pending), 32'(pend_v));
        if (bus.stall) n_pc = m_pc;
        else if (itake) n_pc = vec;
        else if (etake) n_pc = 32'h8000_0008;
        else case (bus.pcsrc)
          3'b001: n_pc = bus.branch_taken ? pp4 + 32'(int'($signed(bus.imm16)) * 4) : pp4;
          3'b010: n_pc = (pp4 & 32'hF000_0000) | (32'(bus.jidx) * 4);
          3'b011: n_pc = bus.jr_target;
          3'b100: n_pc = m_epc;
          default: n_pc = pp4;
        endcase
        n_epc = itake ? m_pc : etake ? pp4 : m_epc;
        for (int i = 0; i < N; i++)
          n_pend[i] = (itake && i == id) ? 1'b0 : (m_pend[i] || (bus.irq[i] && !m_prev[i]));
      end
      @(posedge clk);
      if (reset) model_reset();
      else begin
        m_pc = n_pc; m_epc = n_epc;
        for (int i = 0; i < N; i++) begin m_pend[i] = n_pend[i]; m_prev[i] = bus.irq[i]; end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall = 0; bus.pcsrc = 3'b000; bus.branch_taken = 0; bus.imm16 = '0; bus.jidx = '0;
    bus.jr_target = '0; bus.illegal_op = 0; bus.irq = '0; bus.irq_mask = 4'hF;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 chk("lit reset pc", bus.pc, 32'h0);
    chk("lit reset trap", 32'(bus.trap), 32'd0);
    step(); chk("lit seq pc4", bus.pc, 32'h4);
    step(); chk("lit seq pc8", bus.pc, 32'h8);
    step(); chk("lit seq pcC", bus.pc, 32'hC);
    chk("lit seq epc", bus.epc, 32'h0);
    bus.pcsrc = 3'b010; bus.jidx = 26'h10;
    step(); chk("lit jump 40", bus.pc, 32'h40);
    bus.pcsrc = 3'b001; bus.branch_taken = 1; bus.imm16 = 16'hFFFE;
    step(); chk("lit branch back", bus.pc, 32'h3C);
    bus.pcsrc = 3'b010; bus.jidx = 26'h100;
    step(); chk("lit jump 400", bus.pc, 32'h400);
    bus.pcsrc = 3'b001; bus.branch_taken = 0;
    step(); chk("lit branch not taken", bus.pc, 32'h404);
    bus.pcsrc = 3'b011; bus.jr_target = 32'h0000_0080;
    step(); chk("lit jr", bus.pc, 32'h80);
    bus.pcsrc = 3'b111;
    step(); chk("lit unused pcsrc", bus.pc, 32'h84);
    // two lines rise together; line 1 wins
    bus.pcsrc = 3'b010; bus.jidx = 26'h40; bus.irq = 4'b0110;
    step(); chk("lit pc 100", bus.pc, 32'h100);
    bus.pcsrc = 3'b000;
    #1 chk("lit irq trap", 32'(bus.trap), 32'd1);
    chk("lit irq id1", 32'(bus.trap_id), 32'd1);
    chk("lit irq link", bus.link_value, 32'h100);
    step(); chk("lit vec1", bus.pc, VEC1);
    chk("lit epc 100", bus.epc, 32'h100);
    chk("lit pend 0100", 32'(bus.pending), 32'h4);
    chk("lit kernel", 32'(bus.kernel), 32'd1);
    bus.pcsrc = 3'b100;
    step(); chk("lit eret 100", bus.pc, 32'h100);
    bus.pcsrc = 3'b000;
    #1 chk("lit irq id2", 32'(bus.trap_id), 32'd2);
    step(); chk("lit vec2", bus.pc, VEC2);
    bus.pcsrc = 3'b100; bus.irq = '0;
    step(); chk("lit pend clear", 32'(bus.pending), 32'h0);
    // irq beats illegal op
    bus.pcsrc = 3'b010; bus.jidx = 26'h80; bus.irq = 4'b0001;
    step(); chk("lit pc 200", bus.pc, 32'h200);
    bus.pcsrc = 3'b000; bus.illegal_op = 1;
    #1 chk("lit irq over exc", 32'(bus.trap_irq), 32'd1);
    step(); chk("lit epc 200", bus.epc, 32'h200);
    chk("lit vec0", bus.pc, 32'h8000_0004);
    bus.pcsrc = 3'b100; bus.irq = '0;
    #1 chk("lit kernel ignores illegal", 32'(bus.trap), 32'd0);
    step(); chk("lit eret 200", bus.pc, 32'h200);
    bus.pcsrc = 3'b000;
    #1 chk("lit exc trap", 32'(bus.trap), 32'd1);
    chk("lit exc link", bus.link_value, 32'h204);
    step(); chk("lit exc vec", bus.pc, 32'h8000_0008);
    chk("lit exc epc", bus.epc, 32'h204);
    bus.illegal_op = 0; bus.pcsrc = 3'b100;
    step(); chk("lit eret 204", bus.pc, 32'h204);
    // masked line stays pending without trapping
    bus.pcsrc = 3'b000; bus.stall = 1; bus.irq_mask = 4'b0111; bus.irq = 4'b1000;
    step(); chk("lit stall pc", bus.pc, 32'h204);
    chk("lit masked no trap", 32'(bus.trap), 32'd0);
    bus.irq_mask = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step(); chk("lit stall hold", bus.pc, 32'h204);
      chk("lit stall no trap", 32'(bus.trap), 32'd0);
    end
    bus.stall = 0;
    #1 chk("lit stall release trap", 32'(bus.trap), 32'd1);
    chk("lit stall release id", 32'(bus.trap_id), 32'd3);
    reset = 1;
    #1 chk("lit mid reset pc", bus.pc, 32'h0);
    chk("lit mid reset pend", 32'(bus.pending), 32'h0);
    chk("lit mid reset trap", 32'(bus.trap), 32'd0);
    bus.irq = '0;
    step(); step();
    reset = 0;
    step(); chk("lit post reset pc", bus.pc, 32'h4);
    chk("lit post reset epc", bus.epc, 32'h0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
